// File: rtl/demux1to16_reg.sv
// Sequential 1-to-16 demultiplexer: stages addressed or auto-sequenced bits in a shadow register
// and publishes them atomically to out. Define DEMUX_MSB_FIRST_EN for MSB-first auto framing.
module demux1to16_reg #(
    parameter int unsigned SEL_W = 4,
    parameter int unsigned N     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic [SEL_W-1:0] sel,
    input  logic             in_valid,
    input  logic             auto_en,
    input  logic             commit,
    output logic [N-1:0]     out,
    output logic [SEL_W-1:0] ptr,
    output logic             frame_done
);

`ifdef DEMUX_MSB_FIRST_EN
    localparam logic [SEL_W-1:0] PtrFirst = '1;
    localparam logic [SEL_W-1:0] PtrLast  = '0;
    localparam logic [SEL_W-1:0] PtrStep  = '1;
`else
    localparam logic [SEL_W-1:0] PtrFirst = '0;
    localparam logic [SEL_W-1:0] PtrLast  = '1;
    localparam logic [SEL_W-1:0] PtrStep  = SEL_W'(1);
`endif

    logic [N-1:0]     shadow_q, shadow_d;
    logic [N-1:0]     out_q, out_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             done_q, done_d;
    logic [SEL_W-1:0] wr_idx;

    always_comb begin
        shadow_d = shadow_q;
        out_d    = out_q;
        ptr_d    = ptr_q;
        done_d   = 1'b0;
        wr_idx   = auto_en ? ptr_q : sel;

        // shadow_d already holds this cycle's write, so a publish in the same cycle includes it
        if (in_valid) begin
            shadow_d[wr_idx] = in;
        end

        if (auto_en) begin
            if (in_valid) begin
                ptr_d = ptr_q + PtrStep;
                if (ptr_q == PtrLast) begin
                    out_d  = shadow_d;
                    done_d = 1'b1;
                end
            end
        end else begin
            ptr_d = PtrFirst;
            if (commit) begin
                out_d  = shadow_d;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            out_q    <= '0;
            ptr_q    <= PtrFirst;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            out_q    <= out_d;
            ptr_q    <= ptr_d;
            done_q   <= done_d;
        end
    end

    assign out        = out_q;
    assign ptr        = ptr_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_demux1to16_reg.sv
// Self-checking bench for demux1to16_reg: vector table, directed frame sequences and random
// stimulus against a bit-array reference model. Honours DEMUX_MSB_FIRST_EN like the design.
module tb_demux1to16_reg;

`ifdef DEMUX_MSB_FIRST_EN
    localparam bit MsbFirst = 1'b1;
`else
    localparam bit MsbFirst = 1'b0;
`endif
    localparam int PtrFirst = MsbFirst ? 15 : 0;
    localparam int PtrLast  = MsbFirst ? 0 : 15;

    logic        clk = 1'b0;
    logic        rst, din, in_valid, auto_en, commit;
    logic [3:0]  sel;
    logic [15:0] dout;
    logic [3:0]  ptr;
    logic        frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic        m_bits [16];
    logic [15:0] m_out;
    int          m_pos;
    logic        m_done;

    typedef struct {
        logic        r, d, v, a, c;
        logic [3:0]  s;
        logic [15:0] exp_out;
        logic        exp_done;
    } vec_t;

    vec_t vecs [23];

    demux1to16_reg #(.SEL_W(4), .N(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in         (din),
        .sel        (sel),
        .in_valid   (in_valid),
        .auto_en    (auto_en),
        .commit     (commit),
        .out        (dout),
        .ptr        (ptr),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_word();
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = m_bits[i];
        return w;
    endfunction

    task automatic model_step(input logic r, d, input logic [3:0] s, input logic v, a, c);
        m_done = 1'b0;
        if (r) begin
            for (int i = 0; i < 16; i++) m_bits[i] = 1'b0;
            m_out = '0;
            m_pos = PtrFirst;
        end else if (a) begin
            if (v) begin
                m_bits[m_pos] = d;
                if (m_pos == PtrLast) begin
                    m_out  = model_word();
                    m_done = 1'b1;
                end
                m_pos = MsbFirst ? (m_pos + 15) % 16 : (m_pos + 1) % 16;
            end
        end else begin
            if (v) m_bits[int'(s)] = d;
            m_pos = PtrFirst;
            if (c) begin
                m_out  = model_word();
                m_done = 1'b1;
            end
        end
    endtask

    // one clock: drive, let the edge sample, then compare DUT with the model
    task automatic tick(input logic r, d, input logic [3:0] s, input logic v, a, c);
        rst = r; din = d; sel = s; in_valid = v; auto_en = a; commit = c;
        @(posedge clk);
        #1;
        model_step(r, d, s, v, a, c);
        check("model_out", 32'(dout), 32'(m_out));
        check("model_ptr", 32'(ptr), 32'(m_pos));
        check("model_done", 32'(frame_done), 32'(m_done));
    endtask

    // stream one word in auto mode; gap_mask bit k inserts an idle cycle before bit k
    task automatic stream_word(input logic [15:0] word, input logic [15:0] gap_mask,
                               input string name);
        int pulses = 0;
        int idx;
        check({name, "_ptr_start"}, 32'(ptr), 32'(PtrFirst));
        for (int k = 0; k < 16; k++) begin
            if (gap_mask[k]) begin
                tick(1'b0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
                if (frame_done) pulses++;
            end
            idx = MsbFirst ? 15 - k : k;
            tick(1'b0, word[idx], 4'(15 - k), 1'b1, 1'b1, 1'b1);
            if (frame_done) pulses++;
        end
        check({name, "_out"}, 32'(dout), 32'(word));
        check({name, "_done_last"}, 32'(frame_done), 32'd1);
        check({name, "_pulses"}, 32'(pulses), 32'd1);
        check({name, "_ptr_end"}, 32'(ptr), 32'(PtrFirst));
    endtask

    initial begin
        logic [15:0] w;
        int s;
        int pulses;
        logic r_a;

        rst = 1'b1; din = 1'b0; sel = '0; in_valid = 1'b0; auto_en = 1'b0; commit = 1'b0;
        for (int i = 0; i < 16; i++) m_bits[i] = 1'b0;
        m_out = '0; m_pos = PtrFirst; m_done = 1'b0;

        // vector table: reset with valid+commit, scrambled manual writes, commits
        w = 16'h3f0a;
        for (int i = 0; i < 23; i++) begin
            vecs[i] = '{r: 1'b0, d: 1'b0, v: 1'b0, a: 1'b0, c: 1'b0, s: 4'd0,
                        exp_out: 16'h0000, exp_done: 1'b0};
        end
        vecs[0].r = 1'b1; vecs[0].v = 1'b1; vecs[0].c = 1'b1; vecs[0].d = 1'b1;
        vecs[1].r = 1'b1; vecs[1].v = 1'b1; vecs[1].c = 1'b1; vecs[1].d = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s = (i * 7) % 16;
            vecs[3 + i].s = 4'(s);
            vecs[3 + i].d = w[s];
            vecs[3 + i].v = 1'b1;
        end
        vecs[19].c = 1'b1; vecs[19].exp_out = 16'h3f0a; vecs[19].exp_done = 1'b1;
        vecs[20].exp_out = 16'h3f0a;
        vecs[21].v = 1'b1; vecs[21].d = 1'b1; vecs[21].c = 1'b1; vecs[21].s = 4'd0;
        vecs[21].exp_out = 16'h3f0b; vecs[21].exp_done = 1'b1;
        vecs[22].exp_out = 16'h3f0b;

        for (int i = 0; i < 23; i++) begin
            tick(vecs[i].r, vecs[i].d, vecs[i].s, vecs[i].v, vecs[i].a, vecs[i].c);
            check($sformatf("vec%0d_out", i), 32'(dout), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_done", i), 32'(frame_done), 32'(vecs[i].exp_done));
            check($sformatf("vec%0d_ptr", i), 32'(ptr), 32'(PtrFirst));
        end

        // auto mode: gapped frame then a back-to-back frame
        tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        stream_word(16'h3f0a, 16'h0888, "auto1");
        stream_word(16'h00ff, 16'h0000, "auto2");

        // mode switch mid-frame: aborted partial frame must not publish
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 1'(k), 4'd0, 1'b1, 1'b1, 1'b0);
            if (frame_done) pulses++;
        end
        tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        if (frame_done) pulses++;
        check("switch_ptr_cleared", 32'(ptr), 32'(PtrFirst));
        check("switch_out_held", 32'(dout), 32'h00ff);
        check("switch_no_pulse", 32'(pulses), 32'd0);
        stream_word(16'hc3a5, 16'h0000, "switch");

        // reset mid-frame
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
            if (frame_done) pulses++;
        end
        tick(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        check("midrst_out", 32'(dout), 32'h0000);
        check("midrst_no_pulse", 32'(pulses), 32'd0);
        stream_word(16'h1234, 16'h0000, "midrst");

        // random stimulus against the model
        r_a = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(15) == 0) r_a = ~r_a;
            tick(($urandom_range(63) == 0), 1'($urandom), 4'($urandom),
                 ($urandom_range(3) != 0), r_a, ($urandom_range(7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
